hazard_detect_unit: RTL and testbench



---
 rtl/hazard_detect_unit_if.sv | 35 +++
 rtl/hazard_detect_unit.sv | 107 ++++++++++
 tb/tb_hazard_detect_unit.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_detect_unit_if.sv
// Decode-to-hazard-resolver bus: ID-stage operand/destination fields in,
// stall/bubble and registered forwarding selects out.
interface hazard_detect_unit_if #(
    parameter int REG_W = 2,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [1:0]       id_has_hazard;
    logic [REG_W-1:0] id_ra;
    logic [REG_W-1:0] id_rb;
    logic             id_wr_en;
    logic [REG_W-1:0] id_rd;
    logic             id_is_load;
    logic             flush;
    logic             mem_stall;
    logic             stall;
    logic             bubble;
    logic [1:0]       ex_fwd_a;
    logic [1:0]       ex_fwd_b;
    logic [CNT_W-1:0] stall_count;

    // No valid/ready handshake: id_valid qualifies the ID fields for one cycle,
    // and stall is a same-cycle hold request back to the fetch/decode stages.
    modport master (
        output id_valid, id_has_hazard, id_ra, id_rb, id_wr_en, id_rd,
               id_is_load, flush, mem_stall,
        input  stall, bubble, ex_fwd_a, ex_fwd_b, stall_count
    );

    modport slave (
        input  id_valid, id_has_hazard, id_ra, id_rb, id_wr_en, id_rd,
               id_is_load, flush, mem_stall,
        output stall, bubble, ex_fwd_a, ex_fwd_b, stall_count
    );
endinterface

// File: rtl/hazard_detect_unit.sv
// Load-use stall detection and registered EX forwarding selects, driven by a
// two-entry (EX, MEM) destination tracker, plus a saturating stall counter.
module hazard_detect_unit #(
    parameter int REG_W = 2,
    parameter int CNT_W = 16
) (
    input logic                clk,
    input logic                rst_n,
    hazard_detect_unit_if.slave bus
);

    typedef struct packed {
        logic             valid;
        logic             wr_en;
        logic [REG_W-1:0] rd;
        logic             is_load;
    } entry_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    entry_t           r_ex;
    entry_t           r_mem;
    logic [1:0]       r_fwd_a;
    logic [1:0]       r_fwd_b;
    logic [CNT_W-1:0] r_cnt;

    logic   w_use_a;
    logic   w_use_b;
    logic   w_hit_ex_a;
    logic   w_hit_ex_b;
    logic   w_hit_mem_a;
    logic   w_hit_mem_b;
    logic   w_stall;
    logic   [1:0] w_fwd_a;
    logic   [1:0] w_fwd_b;
    entry_t w_id_entry;

    assign w_use_a = bus.id_valid & bus.id_has_hazard[1];
    assign w_use_b = bus.id_valid & bus.id_has_hazard[0];

    assign w_hit_ex_a  = w_use_a & r_ex.valid  & r_ex.wr_en  & (r_ex.rd  == bus.id_ra);
    assign w_hit_ex_b  = w_use_b & r_ex.valid  & r_ex.wr_en  & (r_ex.rd  == bus.id_rb);
    assign w_hit_mem_a = w_use_a & r_mem.valid & r_mem.wr_en & (r_mem.rd == bus.id_ra);
    assign w_hit_mem_b = w_use_b & r_mem.valid & r_mem.wr_en & (r_mem.rd == bus.id_rb);

    // A load in EX has no result yet, so a dependent ID instruction must wait a cycle.
    assign w_stall = (w_hit_ex_a | w_hit_ex_b) & r_ex.is_load & ~bus.flush;

    always_comb begin
        w_fwd_a = FWD_RF;
        w_fwd_b = FWD_RF;
        if (w_hit_ex_a) begin
            w_fwd_a = FWD_EX;
        end else if (w_hit_mem_a) begin
            w_fwd_a = FWD_MEM;
        end
        if (w_hit_ex_b) begin
            w_fwd_b = FWD_EX;
        end else if (w_hit_mem_b) begin
            w_fwd_b = FWD_MEM;
        end
    end

    assign w_id_entry = '{valid:   bus.id_valid,
                          wr_en:   bus.id_wr_en,
                          rd:      bus.id_rd,
                          is_load: bus.id_is_load};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex    <= '0;
            r_mem   <= '0;
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
            r_cnt   <= '0;
        end else if (bus.mem_stall) begin
            // Frozen pipeline, but a taken branch still kills the EX instruction.
            if (bus.flush) begin
                r_ex    <= '0;
                r_fwd_a <= FWD_RF;
                r_fwd_b <= FWD_RF;
            end
        end else if (bus.flush || w_stall) begin
            r_mem   <= r_ex;
            r_ex    <= '0;
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
            if (w_stall && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else begin
            r_mem   <= r_ex;
            r_ex    <= w_id_entry;
            r_fwd_a <= w_fwd_a;
            r_fwd_b <= w_fwd_b;
        end
    end

    assign bus.stall       = w_stall;
    assign bus.bubble      = w_stall;
    assign bus.ex_fwd_a    = r_fwd_a;
    assign bus.ex_fwd_b    = r_fwd_b;
    assign bus.stall_count = r_cnt;

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Bench for hazard_detect_unit: directed scenarios plus randomized traffic against
// an instruction-level pipeline model; a second DUT with a 2-bit counter shows saturation.
module tb_hazard_detect_unit;

  logic clk;
  logic rst_n;

  logic       d_valid;
  logic [1:0] d_haz;
  logic [1:0] d_ra;
  logic [1:0] d_rb;
  logic       d_wr;
  logic [1:0] d_rd;
  logic       d_ld;
  logic       d_flush;
  logic       d_mem_stall;

  int tests_run;
  int tests_failed;

  hazard_detect_unit_if #(.REG_W(2), .CNT_W(16)) bus ();
  hazard_detect_unit_if #(.REG_W(2), .CNT_W(2))  bus_s ();

  assign bus.id_valid        = d_valid;
  assign bus.id_has_hazard   = d_haz;
  assign bus.id_ra           = d_ra;
  assign bus.id_rb           = d_rb;
  assign bus.id_wr_en        = d_wr;
  assign bus.id_rd           = d_rd;
  assign bus.id_is_load      = d_ld;
  assign bus.flush           = d_flush;
  assign bus.mem_stall       = d_mem_stall;
  assign bus_s.id_valid      = d_valid;
  assign bus_s.id_has_hazard = d_haz;
  assign bus_s.id_ra         = d_ra;
  assign bus_s.id_rb         = d_rb;
  assign bus_s.id_wr_en      = d_wr;
  assign bus_s.id_rd         = d_rd;
  assign bus_s.id_is_load    = d_ld;
  assign bus_s.flush         = d_flush;
  assign bus_s.mem_stall     = d_mem_stall;

  hazard_detect_unit #(.REG_W(2), .CNT_W(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  hazard_detect_unit #(.REG_W(2), .CNT_W(2)) u_dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Each in-flight instruction is a record; m_cnt counts stalls without bound
  // and is clamped to each counter width when compared.
  typedef struct {
    bit v;
    bit w;
    int rd;
    bit ld;
  } slot_t;

  slot_t m_ex;
  slot_t m_mem;
  int    m_fa;
  int    m_fb;
  int    m_cnt;

  function automatic bit hit(slot_t s, int r, bit u);
    return u && s.v && s.w && (s.rd == r);
  endfunction

  function automatic bit exp_stall();
    bit ua;
    bit ub;
    ua = d_valid && d_haz[1];
    ub = d_valid && d_haz[0];
    return (hit(m_ex, int'(d_ra), ua) || hit(m_ex, int'(d_rb), ub)) && m_ex.ld && !d_flush;
  endfunction

  function automatic int exp_cnt(int max_val);
    return (m_cnt > max_val) ? max_val : m_cnt;
  endfunction

  task automatic m_reset();
    m_ex  = '{0, 0, 0, 0};
    m_mem = '{0, 0, 0, 0};
    m_fa  = 0;
    m_fb  = 0;
    m_cnt = 0;
  endtask

  // Advance one clock edge and move the model along with it; returns at edge+1.
  task automatic tick();
    bit    ua;
    bit    ub;
    bit    st;
    int    fa;
    int    fb;
    slot_t id;
    ua = d_valid && d_haz[1];
    ub = d_valid && d_haz[0];
    st = exp_stall();
    fa = hit(m_ex, int'(d_ra), ua) ? 1 : (hit(m_mem, int'(d_ra), ua) ? 2 : 0);
    fb = hit(m_ex, int'(d_rb), ub) ? 1 : (hit(m_mem, int'(d_rb), ub) ? 2 : 0);
    id = '{d_valid, d_wr, int'(d_rd), d_ld};
    @(posedge clk);
    if (d_mem_stall) begin
      if (d_flush) begin
        m_ex.v = 0;
        m_fa   = 0;
        m_fb   = 0;
      end
    end else if (d_flush || st) begin
      m_mem  = m_ex;
      m_ex.v = 0;
      m_fa   = 0;
      m_fb   = 0;
      if (st) m_cnt++;
    end else begin
      m_mem = m_ex;
      m_ex  = id;
      m_fa  = fa;
      m_fb  = fb;
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input logic [1:0] haz, input int ra, input int rb,
                       input bit wr, input int rd, input bit ld);
    d_valid = v;
    d_haz   = haz;
    d_ra    = 2'(ra);
    d_rb    = 2'(rb);
    d_wr    = wr;
    d_rd    = 2'(rd);
    d_ld    = ld;
  endtask

  task automatic idle();
    drive(0, 2'b00, 0, 0, 0, 0, 0);
    d_flush     = 0;
    d_mem_stall = 0;
  endtask

  task automatic drain();
    idle();
    tick();
    tick();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle();
    m_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    m_reset();
    #1;
    tests_run++;
    if ({bus.stall, bus.bubble, bus.ex_fwd_a, bus.ex_fwd_b} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got stall=%b bubble=%b fa=%b fb=%b want all 0",
               bus.stall, bus.bubble, bus.ex_fwd_a, bus.ex_fwd_b);
    end
    tests_run++;
    if (bus.stall_count !== 16'd0 || bus_s.stall_count !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_count: got %0d/%0d want 0/0", bus.stall_count, bus_s.stall_count);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu_forward();
    drive(1, 2'b00, 0, 0, 1, 2, 0);
    tick();
    drive(1, 2'b10, 2, 0, 0, 0, 0);
    #1;
    tests_run++;
    if (bus.stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL alu_no_stall: got %b want 0", bus.stall);
    end
    tick();
    tests_run++;
    if (bus.ex_fwd_a !== 2'b01 || bus.ex_fwd_b !== 2'b00) begin
      tests_failed++;
      $display("FAIL alu_fwd_ex: got fa=%b fb=%b want 01/00", bus.ex_fwd_a, bus.ex_fwd_b);
    end
    drain();
  endtask

  task automatic test_mem_forward();
    drive(1, 2'b00, 0, 0, 1, 1, 0);
    tick();
    drive(1, 2'b00, 0, 0, 1, 3, 0);
    tick();
    drive(1, 2'b01, 2, 1, 0, 0, 0);
    tick();
    tests_run++;
    if (bus.ex_fwd_b !== 2'b10 || bus.ex_fwd_a !== 2'b00) begin
      tests_failed++;
      $display("FAIL mem_fwd_b: got fa=%b fb=%b want 00/10", bus.ex_fwd_a, bus.ex_fwd_b);
    end
    drive(1, 2'b00, 0, 0, 1, 1, 0);
    tick();
    drive(1, 2'b00, 1, 1, 0, 0, 0);
    tick();
    tests_run++;
    if (bus.ex_fwd_a !== 2'b00 || bus.ex_fwd_b !== 2'b00) begin
      tests_failed++;
      $display("FAIL no_hazard_flag: got fa=%b fb=%b want 00/00", bus.ex_fwd_a, bus.ex_fwd_b);
    end
    drain();
  endtask

  task automatic test_load_use();
    drive(1, 2'b00, 0, 0, 1, 3, 1);
    tick();
    drive(1, 2'b11, 3, 3, 0, 0, 0);
    #1;
    tests_run++;
    if ({bus.stall, bus.bubble} !== 2'b11) begin
      tests_failed++;
      $display("FAIL load_use_stall: got stall=%b bubble=%b want 1/1", bus.stall, bus.bubble);
    end
    tick();
    tests_run++;
    if (bus.stall_count !== 16'd1 || bus.ex_fwd_a !== 2'b00 || bus.ex_fwd_b !== 2'b00) begin
      tests_failed++;
      $display("FAIL load_use_bubble: got cnt=%0d fa=%b fb=%b want 1/00/00",
               bus.stall_count, bus.ex_fwd_a, bus.ex_fwd_b);
    end
    tests_run++;
    if (bus.stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_use_one_cycle: got stall=%b want 0", bus.stall);
    end
    tick();
    tests_run++;
    if (bus.ex_fwd_a !== 2'b10 || bus.ex_fwd_b !== 2'b10) begin
      tests_failed++;
      $display("FAIL load_use_fwd_mem: got fa=%b fb=%b want 10/10", bus.ex_fwd_a, bus.ex_fwd_b);
    end
    drain();
  endtask

  task automatic test_flush();
    drive(1, 2'b00, 0, 0, 1, 2, 1);
    tick();
    drive(1, 2'b10, 2, 0, 0, 0, 0);
    d_flush = 1;
    #1;
    tests_run++;
    if (bus.stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_no_stall: got %b want 0", bus.stall);
    end
    tick();
    d_flush = 0;
    tests_run++;
    if (bus.ex_fwd_a !== 2'b00 || bus.stall_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL flush_state: got fa=%b cnt=%0d want 00/1", bus.ex_fwd_a, bus.stall_count);
    end
    // EX is empty now; the load sits in MEM, so a dependent reads it from MEM.
    #1;
    tests_run++;
    if (bus.stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_ex_cleared: got stall=%b want 0", bus.stall);
    end
    tick();
    tests_run++;
    if (bus.ex_fwd_a !== 2'b10) begin
      tests_failed++;
      $display("FAIL flush_then_mem_fwd: got fa=%b want 10", bus.ex_fwd_a);
    end
    drain();
  endtask

  task automatic test_mem_stall();
    drive(1, 2'b00, 0, 0, 1, 1, 1);
    tick();
    drive(1, 2'b10, 1, 0, 0, 0, 0);
    d_mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (bus.stall !== 1'b1) begin
        tests_failed++;
        $display("FAIL mem_stall_stall_%0d: got %b want 1", i, bus.stall);
      end
      tick();
      tests_run++;
      if (bus.stall_count !== 16'd1 || bus.ex_fwd_a !== 2'b00) begin
        tests_failed++;
        $display("FAIL mem_stall_frozen_%0d: got cnt=%0d fa=%b want 1/00", i,
                 bus.stall_count, bus.ex_fwd_a);
      end
    end
    d_mem_stall = 0;
    #1;
    tests_run++;
    if (bus.stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL mem_stall_release: got %b want 1", bus.stall);
    end
    tick();
    tests_run++;
    if (bus.stall_count !== 16'd2 || bus.stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL mem_stall_resolve: got cnt=%0d stall=%b want 2/0", bus.stall_count, bus.stall);
    end
    tick();
    tests_run++;
    if (bus.ex_fwd_a !== 2'b10) begin
      tests_failed++;
      $display("FAIL mem_stall_fwd: got fa=%b want 10", bus.ex_fwd_a);
    end
    drain();
  endtask

  task automatic test_saturate();
    logic [1:0] exp_tbl [5];
    exp_tbl = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 2'b00, 0, 0, 1, i % 4, 1);
      tick();
      drive(1, 2'b10, i % 4, 0, 0, 0, 0);
      tick();
      tests_run++;
      if (bus_s.stall_count !== exp_tbl[i] || bus.stall_count !== 16'(i + 1)) begin
        tests_failed++;
        $display("FAIL saturate_%0d: got %0d/%0d want %0d/%0d", i, bus_s.stall_count,
                 bus.stall_count, exp_tbl[i], i + 1);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_async_reset();
    drive(1, 2'b00, 0, 0, 1, 2, 0);
    tick();
    drive(1, 2'b00, 0, 0, 1, 0, 1);
    tick();
    drive(1, 2'b10, 0, 0, 0, 0, 0);
    #1;
    tests_run++;
    if (bus.stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_pre_stall: got %b want 1", bus.stall);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.stall, bus.bubble, bus.ex_fwd_a, bus.ex_fwd_b} !== 6'b0 ||
        bus.stall_count !== 16'd0 || bus_s.stall_count !== 2'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got stall=%b bubble=%b fa=%b fb=%b cnt=%0d/%0d want 0",
               bus.stall, bus.bubble, bus.ex_fwd_a, bus.ex_fwd_b, bus.stall_count,
               bus_s.stall_count);
    end
    m_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    drive(1, 2'b00, 0, 0, 1, 3, 0);
    tick();
    drive(1, 2'b01, 0, 3, 0, 0, 0);
    tick();
    tests_run++;
    if (bus.ex_fwd_b !== 2'b01 || bus.ex_fwd_a !== 2'b00 || bus.stall_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL async_after_release: got fa=%b fb=%b cnt=%0d want 00/01/0",
               bus.ex_fwd_a, bus.ex_fwd_b, bus.stall_count);
    end
    drain();
  endtask

  task automatic test_random();
    bit es;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            ($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
            ($urandom_range(0, 2) == 0));
      d_flush     = ($urandom_range(0, 9) == 0);
      d_mem_stall = ($urandom_range(0, 5) == 0);
      #1;
      es = exp_stall();
      tests_run++;
      if (bus.stall !== es || bus.bubble !== es) begin
        tests_failed++;
        $display("FAIL rand_stall_%0d: got stall=%b bubble=%b want %b", i, bus.stall,
                 bus.bubble, es);
      end
      tick();
      tests_run++;
      if (bus.ex_fwd_a !== 2'(m_fa) || bus.ex_fwd_b !== 2'(m_fb) ||
          bus.stall_count !== 16'(exp_cnt(65535)) || bus_s.stall_count !== 2'(exp_cnt(3))) begin
        tests_failed++;
        $display("FAIL rand_state_%0d: got fa=%b fb=%b cnt=%0d/%0d want %0d/%0d/%0d/%0d", i,
                 bus.ex_fwd_a, bus.ex_fwd_b, bus.stall_count, bus_s.stall_count,
                 m_fa, m_fb, exp_cnt(65535), exp_cnt(3));
      end
    end
    drain();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_alu_forward();
    test_mem_forward();
    test_load_use();
    test_flush();
    test_mem_stall();
    test_saturate();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
